// File: rtl/stream_head_trim.sv
`default_nettype none
// ============================================================================
// Module   : stream_head_trim
// Brief    : Removes a per-packet count of leading bytes from a byte-keep
//            stream. Drops whole beats and realigns the residual byte shift.
// Revision : 1.0 - initial release
// ============================================================================
module stream_head_trim #(
    parameter int DATA_WD          = 32,
    parameter int DATA_BYTE_WD     = DATA_WD / 8,
    parameter int MAX_REMOVE_BYTES = 16,
    parameter int CNT_WD           = $clog2(MAX_REMOVE_BYTES + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [DATA_WD-1:0]      s_data,
    input  logic [DATA_BYTE_WD-1:0] s_keep,
    input  logic                    s_last,

    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [DATA_WD-1:0]      m_data,
    output logic [DATA_BYTE_WD-1:0] m_keep,
    output logic                    m_last,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [CNT_WD-1:0]       cmd_remove_cnt,

    output logic                    drop_pulse
);

    localparam int                c_sh_wd   = (DATA_BYTE_WD > 1) ? $clog2(DATA_BYTE_WD) : 1;
    localparam logic [CNT_WD-1:0] c_max_cnt = CNT_WD'(MAX_REMOVE_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SKIP  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [CNT_WD-1:0]       w_cnt_sat;
    logic [CNT_WD-1:0]       w_cmd_skip;
    logic [c_sh_wd-1:0]      w_cmd_shift;
    logic [CNT_WD-1:0]       r_skip;
    logic [CNT_WD-1:0]       w_skip_nxt;
    logic [c_sh_wd-1:0]      r_shift;
    logic [c_sh_wd-1:0]      w_shift_nxt;
    logic                    r_first;
    logic                    w_first_nxt;

    logic [DATA_WD-1:0]      r_h_data;
    logic [DATA_BYTE_WD-1:0] r_h_keep;

    logic                    w_flushing;
    logic                    w_use_h;
    logic [DATA_WD-1:0]      w_lo_data;
    logic [DATA_BYTE_WD-1:0] w_lo_keep;
    logic [2*DATA_WD-1:0]    w_cat_data;
    logic [2*DATA_WD-1:0]    w_cat_data_sh;
    logic [2*DATA_BYTE_WD-1:0] w_cat_keep;
    logic [2*DATA_BYTE_WD-1:0] w_cat_keep_sh;
    logic [DATA_WD-1:0]      w_out_data;
    logic [DATA_BYTE_WD-1:0] w_out_keep;
    logic [DATA_BYTE_WD-1:0] w_tail_keep;

    logic                    w_out_free;
    logic                    w_s_fire;
    logic                    w_load_out;
    logic                    w_out_last;
    logic                    w_load_h;
    logic                    w_drop;

    logic                    r_m_valid;
    logic [DATA_WD-1:0]      r_m_data;
    logic [DATA_BYTE_WD-1:0] r_m_keep;
    logic                    r_m_last;
    logic                    r_drop;

    // Command decode: saturate, then split into whole beats and residual bytes
    assign w_cnt_sat   = (cmd_remove_cnt > c_max_cnt) ? c_max_cnt : cmd_remove_cnt;
    assign w_cmd_skip  = CNT_WD'(w_cnt_sat / DATA_BYTE_WD);
    assign w_cmd_shift = c_sh_wd'(w_cnt_sat % DATA_BYTE_WD);

    assign w_out_free = !r_m_valid || m_ready;
    assign cmd_ready  = (r_state == ST_IDLE);
    assign s_ready    = (r_state == ST_SKIP) || ((r_state == ST_SHIFT) && w_out_free);
    assign w_s_fire   = s_valid && s_ready;

    // The holding register forms the upper half of the window once primed;
    // otherwise the input sits on top and zeros fill in from below.
    assign w_flushing = (r_state == ST_FLUSH);
    assign w_use_h    = w_flushing || ((r_state == ST_SHIFT) && !r_first && (r_shift != '0));
    assign w_lo_data  = w_flushing ? {DATA_WD{1'b0}} : s_data;
    assign w_lo_keep  = w_flushing ? {DATA_BYTE_WD{1'b0}} : s_keep;
    assign w_cat_data = w_use_h ? {r_h_data, w_lo_data} : {s_data, {DATA_WD{1'b0}}};
    assign w_cat_keep = w_use_h ? {r_h_keep, w_lo_keep} : {s_keep, {DATA_BYTE_WD{1'b0}}};

    assign w_cat_data_sh = w_cat_data << {r_shift, 3'b000};
    assign w_cat_keep_sh = w_cat_keep << r_shift;
    assign w_out_data    = w_cat_data_sh[2*DATA_WD-1 -: DATA_WD];
    assign w_out_keep    = w_cat_keep_sh[2*DATA_BYTE_WD-1 -: DATA_BYTE_WD];
    assign w_tail_keep   = s_keep << r_shift;

    always_comb begin
        w_state_nxt = r_state;
        w_skip_nxt  = r_skip;
        w_shift_nxt = r_shift;
        w_first_nxt = r_first;
        w_load_out  = 1'b0;
        w_out_last  = 1'b0;
        w_load_h    = 1'b0;
        w_drop      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_skip_nxt  = w_cmd_skip;
                    w_shift_nxt = w_cmd_shift;
                    w_first_nxt = 1'b1;
                    w_state_nxt = (w_cmd_skip != '0) ? ST_SKIP : ST_SHIFT;
                end
            end

            ST_SKIP: begin
                if (w_s_fire) begin
                    if (s_last) begin
                        w_drop      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_skip_nxt = r_skip - 1'b1;
                        if (r_skip == CNT_WD'(1)) begin
                            w_state_nxt = ST_SHIFT;
                        end
                    end
                end
            end

            ST_SHIFT: begin
                if (w_s_fire) begin
                    if (r_shift == '0) begin
                        w_load_out = 1'b1;
                        w_out_last = s_last;
                        if (s_last) begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else if (r_first) begin
                        w_first_nxt = 1'b0;
                        if (!s_last) begin
                            w_load_h = 1'b1;
                        end else begin
                            // Single-beat remainder: nothing left after the shift means a drop
                            if (w_out_keep != '0) begin
                                w_load_out = 1'b1;
                                w_out_last = 1'b1;
                            end else begin
                                w_drop = 1'b1;
                            end
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_load_out = 1'b1;
                        w_load_h   = 1'b1;
                        if (s_last) begin
                            if (w_tail_keep != '0) begin
                                w_state_nxt = ST_FLUSH;
                            end else begin
                                w_out_last  = 1'b1;
                                w_state_nxt = ST_IDLE;
                            end
                        end
                    end
                end
            end

            ST_FLUSH: begin
                if (w_out_free) begin
                    w_load_out  = 1'b1;
                    w_out_last  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_skip  <= '0;
            r_shift <= '0;
            r_first <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_skip  <= w_skip_nxt;
            r_shift <= w_shift_nxt;
            r_first <= w_first_nxt;
            r_drop  <= w_drop;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_data <= '0;
            r_h_keep <= '0;
        end else if (w_load_h) begin
            r_h_data <= s_data;
            r_h_keep <= s_keep;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_keep  <= '0;
            r_m_last  <= 1'b0;
        end else if (w_load_out) begin
            r_m_valid <= 1'b1;
            r_m_data  <= w_out_data;
            r_m_keep  <= w_out_keep;
            r_m_last  <= w_out_last;
        end else if (m_ready) begin
            r_m_valid <= 1'b0;
        end
    end

    assign m_valid    = r_m_valid;
    assign m_data     = r_m_data;
    assign m_keep     = r_m_keep;
    assign m_last     = r_m_last;
    assign drop_pulse = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_stream_head_trim.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_head_trim
// Brief    : Table-driven packet vectors with a byte-level reference model,
//            plus stall, drop and mid-packet reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_head_trim;

    localparam int DW   = 32;
    localparam int BW   = DW / 8;
    localparam int MAXR = 16;
    localparam int CW   = $clog2(MAXR + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic [BW-1:0] s_keep = '0;
    logic          s_last = 1'b0;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [DW-1:0] m_data;
    logic [BW-1:0] m_keep;
    logic          m_last;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [CW-1:0] cmd_remove_cnt = '0;
    logic          drop_pulse;

    stream_head_trim #(
        .DATA_WD          (DW),
        .DATA_BYTE_WD     (BW),
        .MAX_REMOVE_BYTES (MAXR),
        .CNT_WD           (CW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .s_keep         (s_keep),
        .s_last         (s_last),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .m_keep         (m_keep),
        .m_last         (m_last),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_remove_cnt (cmd_remove_cnt),
        .drop_pulse     (drop_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic [BW-1:0] keep;
        logic          last;
    } beat_t;

    typedef struct {
        int cnt;
        int nbeats;
        int lkb;
        int exp_beats;
        int exp_drop;
    } vec_t;

    beat_t exp_q[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    got_beats = 0;
    int    drops = 0;
    logic  bp_en = 1'b0;
    logic  stall_req = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    always @(negedge clk) begin
        if (bp_en) m_ready = ($urandom_range(0, 3) != 0);
        else       m_ready = !stall_req;
    end

    // Output monitor: scoreboard pop, hold-while-stalled, drop counting
    logic  prev_stall = 1'b0;
    beat_t prev;
    beat_t mon_e;
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("hold", 64'({m_valid, m_last, m_keep, m_data}),
                      64'({1'b1, prev.last, prev.keep, prev.data}));
            if (drop_pulse) drops++;
            if (m_valid && m_ready) begin
                got_beats++;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL beat: unexpected output data=%h keep=%h last=%b, none expected",
                             m_data, m_keep, m_last);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("beat", 64'({m_data, m_keep, m_last}),
                          64'({mon_e.data, mon_e.keep, mon_e.last}));
                end
            end
            prev_stall = m_valid && !m_ready;
            prev.data  = m_data;
            prev.keep  = m_keep;
            prev.last  = m_last;
        end
    end

    task automatic send_cmd(input int c);
        int   t = 0;
        logic f;
        cmd_valid      = 1'b1;
        cmd_remove_cnt = CW'(c);
        do begin
            #1;
            f = cmd_ready;
            @(negedge clk);
            t++;
        end while (!f && t < 200);
        cmd_valid = 1'b0;
        if (!f) timeout_fail("cmd_accept");
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [BW-1:0] k, input logic l);
        int   t = 0;
        logic f;
        s_valid = 1'b1;
        s_data  = d;
        s_keep  = k;
        s_last  = l;
        do begin
            #1;
            f = s_ready;
            @(negedge clk);
            t++;
        end while (!f && t < 200);
        s_valid = 1'b0;
        if (!f) timeout_fail("beat_accept");
    endtask

    task automatic run_case(input vec_t v, input int tag);
        logic [7:0]    bytes[$];
        logic [DW-1:0] words[$];
        logic [BW-1:0] keeps[$];
        logic [DW-1:0] w;
        logic [BW-1:0] k;
        logic [7:0]    b8;
        beat_t         e;
        int            nby, r, base_b, base_d, t;
        for (int b = 0; b < v.nbeats; b++) begin
            nby = (b == v.nbeats - 1) ? v.lkb : BW;
            w = '0;
            k = '0;
            for (int j = 0; j < nby; j++) begin
                b8 = 8'($urandom);
                w[DW-1-8*j -: 8] = b8;
                k[BW-1-j] = 1'b1;
                bytes.push_back(b8);
            end
            words.push_back(w);
            keeps.push_back(k);
        end
        r = (v.cnt > MAXR) ? MAXR : v.cnt;
        for (int i = r; i < bytes.size(); i += BW) begin
            e.data = '0;
            e.keep = '0;
            for (int j = 0; j < BW; j++) begin
                if (i + j < bytes.size()) begin
                    e.data[DW-1-8*j -: 8] = bytes[i+j];
                    e.keep[BW-1-j] = 1'b1;
                end
            end
            e.last = (i + BW >= bytes.size());
            exp_q.push_back(e);
        end
        base_b = got_beats;
        base_d = drops;
        send_cmd(v.cnt);
        for (int b = 0; b < v.nbeats; b++)
            send_beat(words[b], keeps[b], b == v.nbeats - 1);
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            timeout_fail($sformatf("drain[%0d]", tag));
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
        check($sformatf("beats[%0d]", tag), 64'(got_beats - base_b), 64'(v.exp_beats));
        check($sformatf("drops[%0d]", tag), 64'(drops - base_d), 64'(v.exp_drop));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_m_valid"},    64'(m_valid),    64'(0));
        check({tag, "_m_data"},     64'(m_data),     64'(0));
        check({tag, "_m_keep"},     64'(m_keep),     64'(0));
        check({tag, "_m_last"},     64'(m_last),     64'(0));
        check({tag, "_drop_pulse"}, 64'(drop_pulse), 64'(0));
        check({tag, "_s_ready"},    64'(s_ready),    64'(0));
        check({tag, "_cmd_ready"},  64'(cmd_ready),  64'(1));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[14];
        vec_t tmp;
        tbl[0]  = '{0,  3, 2, 3, 0};
        tbl[1]  = '{1,  3, 2, 3, 0};
        tbl[2]  = '{2,  2, 2, 1, 0};
        tbl[3]  = '{6,  3, 3, 2, 0};
        tbl[4]  = '{5,  2, 1, 0, 1};
        tbl[5]  = '{20, 5, 4, 1, 0};
        tbl[6]  = '{16, 4, 4, 0, 1};
        tbl[7]  = '{3,  1, 4, 1, 0};
        tbl[8]  = '{3,  1, 3, 0, 1};
        tbl[9]  = '{4,  1, 4, 0, 1};
        tbl[10] = '{7,  4, 1, 2, 0};
        tbl[11] = '{15, 5, 4, 2, 0};
        tbl[12] = '{16, 5, 1, 1, 0};
        tbl[13] = '{31, 6, 4, 2, 0};

        repeat (2) @(negedge clk);
        #1;
        check_reset_values("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int pass = 0; pass < 2; pass++) begin
            bp_en = (pass == 1);
            foreach (tbl[i]) run_case(tbl[i], i + 100 * pass);
        end
        bp_en = 1'b0;
        repeat (2) @(negedge clk);

        // Packet consumed entirely: one-cycle drop pulse, immediately ready again
        send_cmd(5);
        send_beat(32'h1122_3344, 4'hF, 1'b0);
        send_beat(32'h5500_0000, 4'h8, 1'b1);
        #1;
        check("drop_pulse_hi", 64'(drop_pulse), 64'(1));
        check("drop_cmd_ready", 64'(cmd_ready), 64'(1));
        check("drop_no_valid", 64'(m_valid), 64'(0));
        @(negedge clk);
        #1;
        check("drop_pulse_lo", 64'(drop_pulse), 64'(0));
        @(negedge clk);

        // Downstream stall for three cycles mid-packet
        tmp = '{1, 5, 2, 5, 0};
        fork
            run_case(tmp, 200);
            begin
                repeat (3) @(negedge clk);
                #3 stall_req = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    #2;
                    check("stall_backpressure", 64'({m_valid, s_ready}), 64'(2'b10));
                end
                stall_req = 1'b0;
            end
        join
        @(negedge clk);

        // Asynchronous reset in the middle of a packet
        send_cmd(1);
        send_beat(32'hA0A1_A2A3, 4'hF, 1'b0);
        send_beat(32'hB0B1_B2B3, 4'hF, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tmp = '{1, 3, 2, 3, 0};
        run_case(tmp, 300);

        check("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
